// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, 1 start bit, DATA_LENGTH data bits
// (LSB first), 1 stop bit, no parity.
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   rx        - asynchronous serial input, idle high
//   dout      - last correctly framed data word
//   rx_valid  - one-cycle pulse, dout updated on the same edge
//   rx_busy   - high while a frame is in progress
//   frame_err - one-cycle pulse when the stop bit is sampled low
module uart_rx #(
   parameter int unsigned DATA_LENGTH = 8,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rx,
   output logic [DATA_LENGTH-1:0] dout,
   output logic                   rx_valid,
   output logic                   rx_busy,
   output logic                   frame_err
);

   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_LENGTH) + 1;
   localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state, state_nxt;
   logic                   rx_meta, rx_s, rx_d;
   logic [TICK_W-1:0]      tick, tick_nxt;
   logic [BIT_W-1:0]       bit_cnt, bit_cnt_nxt;
   logic [DATA_LENGTH-1:0] shift, shift_nxt;
   logic [DATA_LENGTH-1:0] dout_nxt;
   logic                   rx_valid_nxt, frame_err_nxt;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tick      <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         dout      <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick      <= tick_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         dout      <= dout_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
         rx_busy   <= (state_nxt != IDLE);
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nxt     = state;
      tick_nxt      = tick;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      dout_nxt      = dout;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;

      unique case (state)
         IDLE: begin
            tick_nxt = '0;
            // Only a high-to-low transition starts a frame, so a held-low
            // line (break) stays idle until it rises and falls again.
            if (!rx_s && rx_d) begin
               state_nxt   = START;
               bit_cnt_nxt = '0;
            end
         end
         START: begin
            if (tick == TICK_MID) begin
               tick_nxt  = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
         end
         DATA: begin
            if (tick == TICK_END) begin
               tick_nxt    = '0;
               shift_nxt   = {rx_s, shift[DATA_LENGTH-1:1]};
               bit_cnt_nxt = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) begin
                  state_nxt = STOP;
               end
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
         end
         STOP: begin
            if (tick == TICK_END) begin
               tick_nxt  = '0;
               state_nxt = IDLE;
               if (rx_s) begin
                  dout_nxt     = shift;
                  rx_valid_nxt = 1'b1;
               end else begin
                  frame_err_nxt = 1'b1;
               end
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_LENGTH=8, OVERSAMPLE=16).
// A bit-level line driver predicts each frame's result and the clock cycle
// at which its pulse must appear; a negedge monitor records what the DUT did.
module tb_uart_rx;

   localparam int DL = 8;
   localparam int OS = 16;
   // Two synchronizer stages plus the edge-detect register before START
   localparam int SYNC_LAT = 3;

   typedef struct {
      int         kind;   // 1 = rx_valid, 2 = frame_err
      longint     cyc;
      logic [7:0] data;
   } ev_t;

   logic          clk;
   logic          rst;
   logic          rx;
   logic [DL-1:0] dout;
   logic          rx_valid;
   logic          rx_busy;
   logic          frame_err;

   ev_t        exp_q[$];
   ev_t        got_q[$];
   ev_t        mon_ev;
   int         total = 0;
   int         bad = 0;
   int         busy_cnt = 0;
   int         viol = 0;
   logic       prev_pulse = 1'b0;
   longint     cyc = 0;
   logic [7:0] model_dout = 8'h00;

   uart_rx #(.DATA_LENGTH(DL), .OVERSAMPLE(OS)) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .dout     (dout),
      .rx_valid (rx_valid),
      .rx_busy  (rx_busy),
      .frame_err(frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with its cycle and the dout seen with it
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid || frame_err) begin
            mon_ev.kind = rx_valid ? 1 : 2;
            mon_ev.cyc  = cyc;
            mon_ev.data = dout;
            got_q.push_back(mon_ev);
            if (prev_pulse || (rx_valid && frame_err)) viol++;
         end
         prev_pulse = rx_valid || frame_err;
         if (rx_busy) busy_cnt++;
      end
   end

   // Drive one frame (called at a negedge, line idle high) and queue the
   // expected outcome: pulse at mid stop bit, OS/2 + (DL+1)*OS after START.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      ev_t        e;
      logic [9:0] bits;
      bits  = {stop_bit, data, 1'b0};
      e.cyc = cyc + SYNC_LAT + OS / 2 + (DL + 1) * OS;
      if (stop_bit) begin
         e.kind     = 1;
         e.data     = data;
         model_dout = data;
      end else begin
         e.kind = 2;
         e.data = model_dout;
      end
      exp_q.push_back(e);
      for (int i = 0; i < DL + 2; i++) begin
         rx = bits[i];
         repeat (OS) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (dout !== 8'h00) begin
         bad++;
         $display("FAIL reset_dout got=%h want=00", dout);
      end
      total++;
      if ({rx_valid, rx_busy, frame_err} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags got valid/busy/ferr=%b want=000", {rx_valid, rx_busy, frame_err});
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_frame_a5;
      ev_t e, g;
      busy_cnt = 0;
      send_frame(8'hA5, 1'b1);
      repeat (8) @(negedge clk);
      total++;
      if (busy_cnt !== OS / 2 + (DL + 1) * OS) begin
         bad++;
         $display("FAIL a5_busy_cycles got=%0d want=%0d", busy_cnt, OS / 2 + (DL + 1) * OS);
      end
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL a5_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL a5_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_glitch;
      busy_cnt = 0;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      total++;
      if (busy_cnt !== OS / 2) begin
         bad++;
         $display("FAIL glitch_busy_cycles got=%0d want=%0d", busy_cnt, OS / 2);
      end
      total++;
      if (got_q.size() !== 0) begin
         bad++;
         $display("FAIL glitch_pulses got=%0d want=0", got_q.size());
      end
      total++;
      if (dout !== model_dout || rx_busy !== 1'b0) begin
         bad++;
         $display("FAIL glitch_state got dout=%h busy=%b want dout=%h busy=0", dout, rx_busy, model_dout);
      end
      got_q.delete();
   endtask

   task automatic test_frame_err;
      ev_t e, g;
      send_frame(8'h3C, 1'b0);
      rx = 1'b1;
      repeat (2 * OS) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL ferr_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL ferr_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      total++;
      if (dout !== 8'hA5) begin
         bad++;
         $display("FAIL ferr_dout_kept got=%h want=a5", dout);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      ev_t e, g;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (8) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL b2b_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      if (got_q.size() >= 2) begin
         total++;
         if (got_q[1].cyc - got_q[0].cyc !== longint'((DL + 2) * OS)) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d want=%0d", got_q[1].cyc - got_q[0].cyc, (DL + 2) * OS);
         end
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL b2b_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame;
      ev_t        e, g;
      logic [7:0] data;
      data = 8'($urandom);
      rx   = 1'b0;
      repeat (OS) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = data[i];
         repeat (OS) @(negedge clk);
      end
      rx = data[4];
      repeat (OS / 2) @(negedge clk);
      total++;
      if (rx_busy !== 1'b1) begin
         bad++;
         $display("FAIL midreset_busy_before got=%b want=1", rx_busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({dout, rx_valid, rx_busy, frame_err} !== 11'h000) begin
         bad++;
         $display("FAIL midreset_outputs got dout=%h valid/busy/ferr=%b want all 0",
                  dout, {rx_valid, rx_busy, frame_err});
      end
      model_dout = 8'h00;
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * OS) @(negedge clk);
      send_frame(8'h5A, 1'b1);
      repeat (8) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL midreset_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL midreset_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_break;
      ev_t e, g;
      send_frame(8'($urandom), 1'b0);
      repeat (200) @(negedge clk);
      total++;
      if (rx_busy !== 1'b0) begin
         bad++;
         $display("FAIL break_busy got=%b want=0", rx_busy);
      end
      rx = 1'b1;
      repeat (2 * OS) @(negedge clk);
      send_frame(8'h81, 1'b1);
      repeat (8) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL break_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL break_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_random;
      ev_t  e, g;
      logic stop_bit;
      int   gap;
      for (int n = 0; n < 12; n++) begin
         stop_bit = ($urandom_range(0, 3) != 0);
         send_frame(8'($urandom), stop_bit);
         // A low stop bit leaves the line low; it must rise before the next start
         gap = stop_bit ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
         rx  = 1'b1;
         repeat (gap) @(negedge clk);
      end
      repeat (OS) @(negedge clk);
      total++;
      if (got_q.size() !== exp_q.size()) begin
         bad++;
         $display("FAIL random_event_count got=%0d want=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         total++;
         if (g.kind !== e.kind || g.cyc !== e.cyc || g.data !== e.data) begin
            bad++;
            $display("FAIL random_event got kind=%0d cyc=%0d dout=%h want kind=%0d cyc=%0d dout=%h",
                     g.kind, g.cyc, g.data, e.kind, e.cyc, e.data);
         end
      end
      total++;
      if (dout !== model_dout) begin
         bad++;
         $display("FAIL random_final_dout got=%h want=%h", dout, model_dout);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_pulse_rules;
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL pulse_rules got violations=%0d want=0", viol);
      end
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      test_reset();
      test_frame_a5();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid_frame();
      test_break();
      test_random();
      test_pulse_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
